fetch_unit: RTL and testbench

Instruction-fetch stage of the MIPS pipeline. Owns the program counter, drives the instruction-memory address, captures the returned word into the IF/ID pipeline register, and applies stall, flush, branch/jump/jr redirects and halt/fault stop conditions. Sits directly upstream of the instruction memory, which is a combinational read on word address `address >> 2`, and directly upstream of the decode stage.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, addresses the
// instruction memory, and loads the IF/ID register. Handles stall, flush,
// jr/jump/branch redirects, and the halt and out-of-range stop conditions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_WORDS   = 64,
    parameter logic [5:0]  HALT_OPCODE = 6'b101101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [31:0] inst_in,
    output logic [31:0] inst_addr,
    output logic [31:0] ifid_inst,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        halted,
    output logic        fetch_fault,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        S_WARMUP = 2'd0,
        S_RUN    = 2'd1,
        S_HALT   = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    // Word-index limit of the instruction memory, sized to pc[31:2].
    localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

    state_t      state_p0, state_nxt;
    logic [31:0] pc_p0, pc_nxt;
    logic [31:0] inst_p1, inst_nxt;
    logic [31:0] pc4_p1, pc4_nxt;
    logic        vld_p1, vld_nxt;
    logic [15:0] cnt_p1, cnt_nxt;

    logic [31:0] pc_plus4;
    logic        pc_in_range;
    logic        redirect;
    logic [31:0] redirect_target;

    // Saturating increment so the fetch counter sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign pc_plus4        = pc_p0 + 32'd4;
    assign pc_in_range     = (pc_p0[31:2] < MEM_LIMIT);
    assign redirect        = jr | jump | branch_taken;
    // jr beats jump beats branch; low two bits are dropped to keep word alignment.
    assign redirect_target = (jr   ? jr_target   :
                              jump ? jump_target : branch_target) & 32'hFFFF_FFFC;

    // Next-state and next-register selection; defaults hold everything.
    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        inst_nxt  = inst_p1;
        pc4_nxt   = pc4_p1;
        vld_nxt   = vld_p1;
        cnt_nxt   = cnt_p1;
        case (state_p0)
            S_WARMUP: begin
                // Memory gets one cycle to settle before the first capture.
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!pc_in_range) begin
                    // Out-of-range PC wins over everything, including redirects.
                    state_nxt = S_FAULT;
                    inst_nxt  = 32'h0000_0000;
                    vld_nxt   = 1'b0;
                end else if (redirect) begin
                    // Redirect wins over stall; the word in flight is squashed.
                    pc_nxt   = redirect_target;
                    inst_nxt = 32'h0000_0000;
                    vld_nxt  = 1'b0;
                end else if (stall) begin
                    // Hold PC, IF/ID and the counter.
                end else if (flush) begin
                    pc_nxt   = pc_plus4;
                    inst_nxt = 32'h0000_0000;
                    vld_nxt  = 1'b0;
                end else begin
                    pc_nxt   = pc_plus4;
                    inst_nxt = inst_in;
                    pc4_nxt  = pc_plus4;
                    vld_nxt  = 1'b1;
                    cnt_nxt  = sat_inc16(cnt_p1);
                    // The halt word itself is delivered valid to decode.
                    if (inst_in[31:26] == HALT_OPCODE) begin
                        state_nxt = S_HALT;
                    end
                end
            end
            S_HALT, S_FAULT: begin
                // Terminal: PC frozen, IF/ID bubbles until reset.
                inst_nxt = 32'h0000_0000;
                vld_nxt  = 1'b0;
            end
            default: begin
                state_nxt = S_WARMUP;
            end
        endcase
    end

    // State and pipeline registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= S_WARMUP;
            pc_p0    <= RESET_PC;
            inst_p1  <= 32'h0000_0000;
            pc4_p1   <= 32'h0000_0000;
            vld_p1   <= 1'b0;
            cnt_p1   <= 16'h0000;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
            inst_p1  <= inst_nxt;
            pc4_p1   <= pc4_nxt;
            vld_p1   <= vld_nxt;
            cnt_p1   <= cnt_nxt;
        end
    end

    assign inst_addr     = pc_p0;
    assign ifid_inst     = inst_p1;
    assign ifid_pc_plus4 = pc4_p1;
    assign ifid_valid    = vld_p1;
    assign fetch_count   = cnt_p1;
    assign halted        = (state_p0 == S_HALT);
    assign fetch_fault   = (state_p0 == S_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized runs against a
// behavioural model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, branch_taken, jump, jr;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] inst_in, inst_addr, ifid_inst, ifid_pc_plus4;
    logic        ifid_valid, halted, fetch_fault;
    logic [15:0] fetch_count;

    logic [31:0] mem [64];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_warm, m_halted, m_fault, m_valid;
    logic [31:0] m_pc, m_inst, m_pc4;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    assign inst_in = (inst_addr[31:2] < 30'd64) ? mem[inst_addr[7:2]] : 32'h0;

    fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(64), .HALT_OPCODE(6'b101101)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_target(jr_target),
        .inst_in(inst_in), .inst_addr(inst_addr), .ifid_inst(ifid_inst),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid),
        .halted(halted), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a[31:2] < 30'd64) ? mem[a[7:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] safe_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'b101101) w[31:26] = 6'b000000;
        return w;
    endfunction

    task automatic model_reset();
        m_warm = 1; m_halted = 0; m_fault = 0; m_valid = 0;
        m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_count = 16'h0;
    endtask

    // Apply one rising edge's worth of spec behaviour to the model.
    task automatic model_edge();
        logic [31:0] w;
        if (m_warm) begin
            m_warm = 0;
        end else if (m_halted || m_fault) begin
            m_inst = 0; m_valid = 0;
        end else if ((m_pc >> 2) >= 64) begin
            m_fault = 1; m_inst = 0; m_valid = 0;
        end else if (jr || jump || branch_taken) begin
            if (jr)        m_pc = jr_target;
            else if (jump) m_pc = jump_target;
            else           m_pc = branch_target;
            m_pc = (m_pc / 4) * 4;
            m_inst = 0; m_valid = 0;
        end else if (stall) begin
        end else if (flush) begin
            m_pc = m_pc + 4; m_inst = 0; m_valid = 0;
        end else begin
            w = word_at(m_pc);
            m_inst = w; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
            if (m_count != 16'hFFFF) m_count = m_count + 1;
            if (w[31:26] == 6'b101101) m_halted = 1;
        end
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
        branch_target = 0; jump_target = 0; jr_target = 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        model_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, halted, fetch_fault, fetch_count} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0})
            $display("FAIL reset_values: got pc=%h inst=%h pc4=%h v=%b h=%b f=%b cnt=%0d, want all zero",
                     inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, halted, fetch_fault, fetch_count);
        else n_pass++;
        reset = 0;
        step();
        n_checks++;
        if ({inst_addr, ifid_valid} !== {32'h0, 1'b0})
            $display("FAIL warmup: got pc=%h v=%b, want pc=0 v=0", inst_addr, ifid_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid} !== {32'h8C01_0000, 32'h4, 1'b1})
            $display("FAIL seq_edge2: got inst=%h pc4=%h v=%b, want 8c010000 4 1",
                     ifid_inst, ifid_pc_plus4, ifid_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({ifid_inst, ifid_pc_plus4, fetch_count} !== {32'h3402_0004, 32'h8, 16'd2})
            $display("FAIL seq_edge3: got inst=%h pc4=%h cnt=%0d, want 34020004 8 2",
                     ifid_inst, ifid_pc_plus4, fetch_count);
        else n_pass++;
    endtask

    task automatic test_branch();
        jump = 1; jump_target = 32'h64;
        step();
        clear_inputs();
        n_checks++;
        if ({inst_addr, ifid_valid} !== {32'h64, 1'b0})
            $display("FAIL jump_to_64: got pc=%h v=%b, want 64 0", inst_addr, ifid_valid);
        else n_pass++;
        branch_taken = 1; branch_target = 32'h68;
        step();
        clear_inputs();
        n_checks++;
        if ({inst_addr, ifid_inst, ifid_valid} !== {32'h68, 32'h0, 1'b0})
            $display("FAIL branch_redirect: got pc=%h inst=%h v=%b, want 68 0 0",
                     inst_addr, ifid_inst, ifid_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid} !== {mem[26], 32'h6C, 1'b1})
            $display("FAIL branch_target_fetch: got inst=%h pc4=%h v=%b, want %h 6c 1",
                     ifid_inst, ifid_pc_plus4, ifid_valid, mem[26]);
        else n_pass++;
        jr = 1; jump = 1; jr_target = 32'h10; jump_target = 32'h80;
        step();
        clear_inputs();
        n_checks++;
        if (inst_addr !== 32'h10)
            $display("FAIL jr_over_jump: got pc=%h, want 10", inst_addr);
        else n_pass++;
        jump = 1; branch_taken = 1; jump_target = 32'h40; branch_target = 32'h20;
        step();
        clear_inputs();
        n_checks++;
        if (inst_addr !== 32'h40)
            $display("FAIL jump_over_branch: got pc=%h, want 40", inst_addr);
        else n_pass++;
        branch_taken = 1; branch_target = 32'h2B;
        step();
        clear_inputs();
        n_checks++;
        if (inst_addr !== 32'h28)
            $display("FAIL target_align: got pc=%h, want 28", inst_addr);
        else n_pass++;
        step();
        n_checks++;
        if ({ifid_inst, ifid_pc_plus4, ifid_valid} !== {mem[10], 32'h2C, 1'b1})
            $display("FAIL aligned_fetch: got inst=%h pc4=%h v=%b, want %h 2c 1",
                     ifid_inst, ifid_pc_plus4, ifid_valid, mem[10]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] s_pc, s_inst, s_pc4;
        logic [15:0] s_cnt;
        step();
        s_pc = m_pc; s_inst = m_inst; s_pc4 = m_pc4; s_cnt = m_count;
        for (int i = 0; i < 3; i++) begin
            stall = 1;
            flush = (i == 2);
            step();
            n_checks++;
            if ({inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count} !==
                {s_pc, s_inst, s_pc4, 1'b1, s_cnt})
                $display("FAIL stall_hold[%0d]: got pc=%h inst=%h pc4=%h v=%b cnt=%0d, want %h %h %h 1 %0d",
                         i, inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count,
                         s_pc, s_inst, s_pc4, s_cnt);
            else n_pass++;
        end
        clear_inputs();
        stall = 1; jump = 1; jump_target = 32'h80;
        step();
        clear_inputs();
        n_checks++;
        if ({inst_addr, ifid_inst, ifid_valid} !== {32'h80, 32'h0, 1'b0})
            $display("FAIL stall_vs_jump: got pc=%h inst=%h v=%b, want 80 0 0",
                     inst_addr, ifid_inst, ifid_valid);
        else n_pass++;
    endtask

    task automatic test_halt();
        logic [15:0] c;
        mem[33] = 32'hB422_1820;
        do_reset();
        step();
        jump = 1; jump_target = 32'h84;
        step();
        clear_inputs();
        step();
        c = m_count;
        n_checks++;
        if ({ifid_inst, ifid_valid, halted, inst_addr} !== {32'hB422_1820, 1'b1, 1'b1, 32'h88})
            $display("FAIL halt_capture: got inst=%h v=%b h=%b pc=%h, want b4221820 1 1 88",
                     ifid_inst, ifid_valid, halted, inst_addr);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            jump = (i == 2); jump_target = 32'h10;
            step();
            n_checks++;
            if ({inst_addr, ifid_valid, ifid_inst, halted, fetch_count} !== {32'h88, 1'b0, 32'h0, 1'b1, c})
                $display("FAIL halt_frozen[%0d]: got pc=%h v=%b inst=%h h=%b cnt=%0d, want 88 0 0 1 %0d",
                         i, inst_addr, ifid_valid, ifid_inst, halted, fetch_count, c);
            else n_pass++;
        end
        clear_inputs();
        do_reset();
        step();
        jump = 1; jump_target = 32'h84;
        step();
        clear_inputs();
        flush = 1;
        step();
        clear_inputs();
        n_checks++;
        if ({halted, inst_addr, ifid_valid} !== {1'b0, 32'h88, 1'b0})
            $display("FAIL halt_flushed: got h=%b pc=%h v=%b, want 0 88 0", halted, inst_addr, ifid_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({halted, ifid_inst, ifid_valid} !== {1'b0, mem[34], 1'b1})
            $display("FAIL after_flush: got h=%b inst=%h v=%b, want 0 %h 1", halted, ifid_inst, ifid_valid, mem[34]);
        else n_pass++;
        mem[33] = safe_word();
    endtask

    task automatic test_fault();
        do_reset();
        step();
        step();
        jump = 1; jump_target = 32'h100;
        step();
        clear_inputs();
        n_checks++;
        if ({inst_addr, fetch_fault} !== {32'h100, 1'b0})
            $display("FAIL fault_jump: got pc=%h f=%b, want 100 0", inst_addr, fetch_fault);
        else n_pass++;
        jump = 1; jump_target = 32'h10;
        step();
        clear_inputs();
        n_checks++;
        if ({fetch_fault, inst_addr, ifid_valid} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL fault_detect: got f=%b pc=%h v=%b, want 1 100 0", fetch_fault, inst_addr, ifid_valid);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            branch_taken = 1; branch_target = 32'h8;
            step();
            n_checks++;
            if ({fetch_fault, inst_addr, ifid_valid, fetch_count} !== {1'b1, 32'h100, 1'b0, 16'd1})
                $display("FAIL fault_hold[%0d]: got f=%b pc=%h v=%b cnt=%0d, want 1 100 0 1",
                         i, fetch_fault, inst_addr, ifid_valid, fetch_count);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        #3;
        reset = 1;
        model_reset();
        #1;
        n_checks++;
        if ({inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, halted, fetch_fault, fetch_count} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0})
            $display("FAIL async_reset_immediate: got pc=%h inst=%h pc4=%h v=%b cnt=%0d, want all zero",
                     inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, fetch_count);
        else n_pass++;
        #1;
        reset = 0;
        step();
        n_checks++;
        if ({inst_addr, ifid_valid} !== {32'h0, 1'b0})
            $display("FAIL async_warmup: got pc=%h v=%b, want 0 0", inst_addr, ifid_valid);
        else n_pass++;
        step();
        n_checks++;
        if ({ifid_inst, ifid_valid, fetch_count} !== {mem[0], 1'b1, 16'd1})
            $display("FAIL async_first_fetch: got inst=%h v=%b cnt=%0d, want %h 1 1",
                     ifid_inst, ifid_valid, fetch_count, mem[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        int hidx;
        logic [31:0] saved;
        for (int seg = 0; seg < 4; seg++) begin
            hidx = $urandom_range(2, 63);
            saved = mem[hidx];
            if (seg % 2 == 1) mem[hidx] = 32'hB422_1820;
            do_reset();
            for (int i = 0; i < 80; i++) begin
                stall         = ($urandom % 5) == 0;
                flush         = ($urandom % 6) == 0;
                jr            = ($urandom % 12) == 0;
                jump          = ($urandom % 12) == 0;
                branch_taken  = ($urandom % 8) == 0;
                jr_target     = $urandom_range(0, 280);
                jump_target   = $urandom_range(0, 270);
                branch_target = $urandom_range(0, 260);
                step();
                n_checks++;
                if ({inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, halted, fetch_fault, fetch_count} !==
                    {m_pc, m_inst, m_pc4, m_valid, m_halted, m_fault, m_count})
                    $display("FAIL random[%0d.%0d]: got pc=%h inst=%h pc4=%h v=%b h=%b f=%b cnt=%0d, want %h %h %h %b %b %b %0d",
                             seg, i, inst_addr, ifid_inst, ifid_pc_plus4, ifid_valid, halted, fetch_fault,
                             fetch_count, m_pc, m_inst, m_pc4, m_valid, m_halted, m_fault, m_count);
                else n_pass++;
            end
            mem[hidx] = saved;
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        for (int i = 0; i < 64; i++) mem[i] = safe_word();
        mem[0] = 32'h8C01_0000;
        mem[1] = 32'h3402_0004;
        #2;
        test_reset();
        test_branch();
        test_stall();
        test_halt();
        test_fault();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
